// File: rtl/frame_stack_pkg.sv
// Shared constants, operation encoding and frame helpers for the frame stack.
// Latency: none (declarations only).
// Backpressure: none; full/empty reported by the stack itself.
package frame_stack_pkg;

    // Default geometry: 16-bit words, 8 frames, return address plus one saved register.
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_CHANNELS = 2;

    // Width of the frame counter for the default depth (must hold 0..DEPTH inclusive).
    localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

    // Upper bounds for the generic word extractor below.
    localparam int MAX_FRAME_W = 256;
    localparam int MAX_WORD_W  = 64;

    // Decoded per-cycle action of the stack.
    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_OVF     = 3'd4,
        OP_UNF     = 3'd5
    } stack_op_e;

    // Returns word k (w bits wide) of a frame; word 0 is the return address.
    function automatic logic [MAX_WORD_W-1:0] frame_word(
        input logic [MAX_FRAME_W-1:0] frame,
        input int unsigned            k,
        input int unsigned            w
    );
        logic [MAX_FRAME_W-1:0] shifted;
        logic [MAX_WORD_W-1:0]  mask;
        shifted = frame >> (k * w);
        mask    = (w >= MAX_WORD_W) ? {MAX_WORD_W{1'b1}}
                                    : ((MAX_WORD_W'(1) << w) - MAX_WORD_W'(1));
        return shifted[MAX_WORD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/frame_stack_mem.sv
// DEPTH x FW register array: one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata_o the cycle after the edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
module frame_stack_mem #(
    parameter int FW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          wen_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [FW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [FW-1:0] rdata_o
);

    // Frame storage is deliberately left unreset: it is never visible while the stack is empty.
    logic [FW-1:0] mem_q [DEPTH];

    // Single write port; the stack control guarantees the address is in range.
    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_stack.sv
// DEPTH-deep save/restore stack of CHANNELS-word frames with sticky overflow/underflow.
// Latency: push/pop/replace take effect at the next edge; frameOut is combinational from the top.
// Backpressure: refused pushes (full) and pops (empty) are dropped and flagged, never stalled.
module frame_stack
    import frame_stack_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         backup,
    input  logic                         restore,
    input  logic                         clearErr,
    input  logic [CHANNELS*WIDTH-1:0]    frameIn,
    output logic [CHANNELS*WIDTH-1:0]    frameOut,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int FW = CHANNELS * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          is_full;
    logic          is_empty;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [FW-1:0] rdata;
    stack_op_e     op;

    // Status is derived only from the count register so it cannot glitch with inputs.
    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    // The count is the write pointer; the top sits one below it. At count==DEPTH the
    // low bits wrap to zero and the subtraction still lands on DEPTH-1.
    assign top_idx = count_q[AW-1:0] - AW'(1);

    // Decode backup/restore against the current fill level into one action.
    always_comb begin
        op = OP_HOLD;
        case ({backup, restore})
            2'b10:   op = is_full  ? OP_OVF  : OP_PUSH;
            2'b01:   op = is_empty ? OP_UNF  : OP_POP;
            2'b11:   op = is_empty ? OP_PUSH : OP_REPLACE;
            default: op = OP_HOLD;
        endcase
    end

    // Next count, storage write and sticky flags; a fresh error beats a simultaneous clear.
    always_comb begin
        count_d = count_q;
        wen     = 1'b0;
        waddr   = count_q[AW-1:0];
        ovf_d   = ovf_q & ~clearErr;
        unf_d   = unf_q & ~clearErr;
        case (op)
            OP_PUSH: begin
                wen     = 1'b1;
                count_d = count_q + CW'(1);
            end
            OP_REPLACE: begin
                wen   = 1'b1;
                waddr = top_idx;
            end
            OP_POP: begin
                count_d = count_q - CW'(1);
            end
            OP_OVF: begin
                ovf_d = 1'b1;
            end
            OP_UNF: begin
                unf_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Count and flags; asynchronous reset empties the stack immediately.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    frame_stack_mem #(
        .FW    (FW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wen_i   (wen),
        .waddr_i (waddr),
        .wdata_i (frameIn),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

    // Stale storage must never leak out while empty.
    assign frameOut  = is_empty ? '0 : rdata;
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench: default instance plus an 8-bit, 3-word, 4-deep instance.
// Latency: expected post-edge state is queued at drive time and compared after the edge.
// Backpressure: n/a.
module tb_frame_stack;
    import frame_stack_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        bk, rs, ce;
    logic [31:0] fin_a;
    logic [23:0] fin_b;

    logic [31:0] fo_a;
    logic [3:0]  cnt_a;
    logic        full_a, empty_a, ovf_a, unf_a;
    logic [23:0] fo_b;
    logic [2:0]  cnt_b;
    logic        full_b, empty_b, ovf_b, unf_b;

    int n_chk;
    int n_fail;

    frame_stack u_dut_a (
        .clk(clk), .Reset(rst_n), .backup(bk), .restore(rs), .clearErr(ce),
        .frameIn(fin_a), .frameOut(fo_a), .count(cnt_a), .full(full_a),
        .empty(empty_a), .overflow(ovf_a), .underflow(unf_a)
    );

    frame_stack #(.WIDTH(8), .DEPTH(4), .CHANNELS(3)) u_dut_b (
        .clk(clk), .Reset(rst_n), .backup(bk), .restore(rs), .clearErr(ce),
        .frameIn(fin_b), .frameOut(fo_b), .count(cnt_b), .full(full_b),
        .empty(empty_b), .overflow(ovf_b), .underflow(unf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [63:0] cnt;
        logic [63:0] top;
        bit          full;
        bit          empty;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mst [2][8];
    int          msz [2];
    bit          movf [2];
    bit          munf [2];
    int          mdepth [2];
    logic [63:0] mmask [2];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mtop(input int id);
        if (msz[id] == 0) return 64'd0;
        return mst[id][msz[id]-1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            msz[i]  = 0;
            movf[i] = 1'b0;
            munf[i] = 1'b0;
        end
    endtask

    task automatic model_apply(input int id, input bit b, input bit r, input bit c, input logic [63:0] f);
        logic [63:0] fm;
        fm = f & mmask[id];
        if (c) begin
            movf[id] = 1'b0;
            munf[id] = 1'b0;
        end
        if (b && r && msz[id] > 0) begin
            mst[id][msz[id]-1] = fm;
        end else if (b) begin
            if (msz[id] < mdepth[id]) begin
                mst[id][msz[id]] = fm;
                msz[id]++;
            end else begin
                movf[id] = 1'b1;
            end
        end else if (r) begin
            if (msz[id] > 0) msz[id]--;
            else munf[id] = 1'b1;
        end
    endtask

    task automatic push_expect(input int id);
        exp_t e;
        e.id    = id;
        e.cnt   = 64'(msz[id]);
        e.top   = mtop(id);
        e.full  = (msz[id] == mdepth[id]);
        e.empty = (msz[id] == 0);
        e.ovf   = movf[id];
        e.unf   = munf[id];
        sb.push_back(e);
    endtask

    task automatic compare_out(input exp_t e);
        if (e.id == 0) begin
            chk_eq("cnt_a",   64'(cnt_a),   e.cnt);
            chk_eq("top_a",   64'(fo_a),    e.top);
            chk_eq("full_a",  64'(full_a),  64'(e.full));
            chk_eq("empty_a", 64'(empty_a), 64'(e.empty));
            chk_eq("ovf_a",   64'(ovf_a),   64'(e.ovf));
            chk_eq("unf_a",   64'(unf_a),   64'(e.unf));
        end else begin
            chk_eq("cnt_b",   64'(cnt_b),   e.cnt);
            chk_eq("top_b",   64'(fo_b),    e.top);
            chk_eq("full_b",  64'(full_b),  64'(e.full));
            chk_eq("empty_b", 64'(empty_b), 64'(e.empty));
            chk_eq("ovf_b",   64'(ovf_b),   64'(e.ovf));
            chk_eq("unf_b",   64'(unf_b),   64'(e.unf));
        end
    endtask

    // One clock: drive at negedge, check the top the consumer sees, queue expectations, compare after edge.
    task automatic step(input bit b, input bit r, input bit c, input logic [63:0] f);
        @(negedge clk);
        bk    = b;
        rs    = r;
        ce    = c;
        fin_a = f[31:0];
        fin_b = f[55:32];
        #1;
        chk_eq("pre_top_a", 64'(fo_a), mtop(0));
        chk_eq("pre_top_b", 64'(fo_b), mtop(1));
        model_apply(0, b, r, c, 64'(f[31:0]));
        model_apply(1, b, r, c, 64'(f[55:32]));
        push_expect(0);
        push_expect(1);
        @(posedge clk);
        #1;
        while (sb.size() > 0) compare_out(sb.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] f;
        n_chk     = 0;
        n_fail    = 0;
        mdepth[0] = 8;
        mdepth[1] = 4;
        mmask[0]  = 64'hFFFF_FFFF;
        mmask[1]  = 64'h00FF_FFFF;
        model_reset();
        bk = 1'b0; rs = 1'b0; ce = 1'b0; fin_a = '0; fin_b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_cnt",   64'(cnt_a),   64'd0);
        chk_eq("rst_empty", 64'(empty_a), 64'd1);
        chk_eq("rst_full",  64'(full_a),  64'd0);
        chk_eq("rst_top",   64'(fo_a),    64'd0);
        chk_eq("rst_ovf",   64'(ovf_a),   64'd0);
        chk_eq("rst_unf",   64'(unf_a),   64'd0);
        chk_eq("rst_top_b", 64'(fo_b),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 64'd0);

        // LIFO order over three frames
        step(1, 0, 0, 64'h0000_0011_AAAA_1000);
        step(1, 0, 0, 64'h0000_0022_BBBB_2000);
        step(1, 0, 0, 64'h0000_0033_CCCC_3000);
        chk_eq("lifo_top",   64'(fo_a), 64'h0000_0000_CCCC_3000);
        chk_eq("lifo_ra",    frame_word(256'(fo_a), 0, 16), 64'h3000);
        chk_eq("lifo_w1",    frame_word(256'(fo_a), 1, 16), 64'hCCCC);
        chk_eq("lifo_b_w0",  frame_word(256'(fo_b), 0, 8),  64'h33);
        step(0, 1, 0, 64'd0);
        chk_eq("pop1_top",   64'(fo_a), 64'h0000_0000_BBBB_2000);
        step(0, 1, 0, 64'd0);
        chk_eq("pop2_top",   64'(fo_a), 64'h0000_0000_AAAA_1000);
        step(0, 1, 0, 64'd0);
        chk_eq("pop3_empty", 64'(empty_a), 64'd1);

        // asynchronous reset with frames held
        step(1, 0, 0, 64'h0000_0001_0000_0101);
        step(1, 0, 0, 64'h0000_0002_0000_0202);
        step(1, 0, 0, 64'h0000_0003_0000_0303);
        chk_eq("mid_cnt_pre", 64'(cnt_a), 64'd3);
        @(negedge clk);
        bk = 1'b0; rs = 1'b0; ce = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_cnt",   64'(cnt_a),   64'd0);
        chk_eq("mid_rst_top",   64'(fo_a),    64'd0);
        chk_eq("mid_rst_empty", 64'(empty_a), 64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // fill to DEPTH then overflow
        for (int i = 1; i <= 8; i++) begin
            f = {32'h0, 16'h00E0 + 16'(i), 16'h8000 + 16'(i)};
            step(1, 0, 0, f);
        end
        step(1, 0, 0, 64'h0000_0000_0000_DEAD);
        chk_eq("ovf_full", 64'(full_a), 64'd1);
        chk_eq("ovf_flag", 64'(ovf_a),  64'd1);
        chk_eq("ovf_cnt",  64'(cnt_a),  64'd8);
        chk_eq("ovf_top",  64'(fo_a),   64'h0000_0000_00E8_8008);
        step(0, 0, 1, 64'd0);
        chk_eq("ovf_clear", 64'(ovf_a), 64'd0);

        // drain, then underflow and clear-vs-error priority
        repeat (8) step(0, 1, 0, 64'd0);
        step(0, 1, 0, 64'd0);
        chk_eq("unf_flag", 64'(unf_a), 64'd1);
        chk_eq("unf_cnt",  64'(cnt_a), 64'd0);
        chk_eq("unf_top",  64'(fo_a),  64'd0);
        step(0, 1, 1, 64'd0);
        chk_eq("unf_clr_race", 64'(unf_a), 64'd1);
        step(0, 0, 1, 64'd0);
        chk_eq("unf_cleared", 64'(unf_a), 64'd0);

        // replace in place, and backup+restore on empty
        step(1, 0, 0, 64'h0000_0000_0000_0A0A);
        step(1, 0, 0, 64'h0000_0000_0000_0B0B);
        step(1, 1, 0, 64'h0000_00AB_5555_4444);
        chk_eq("repl_cnt", 64'(cnt_a), 64'd2);
        chk_eq("repl_top", 64'(fo_a),  64'h0000_0000_5555_4444);
        repeat (2) step(0, 1, 0, 64'd0);
        step(1, 1, 0, 64'h0000_0077_1234_5678);
        chk_eq("both_empty_cnt", 64'(cnt_a), 64'd1);
        chk_eq("both_empty_ovf", 64'(ovf_a), 64'd0);
        chk_eq("both_empty_unf", 64'(unf_a), 64'd0);
        chk_eq("both_empty_top", 64'(fo_a),  64'h0000_0000_1234_5678);
        step(0, 1, 0, 64'd0);

        // randomised mix against the reference model
        for (int n = 0; n < 2500; n++) begin
            bit b, r, c;
            b = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 5);
            f = {$urandom, $urandom};
            step(b, r, c, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
